load_store_unit: RTL and testbench

- Initiator side of the data-memory interface: the datapath issues loads and stores; this block drives the word-addressed data memory port.
- Handles byte, halfword and word accesses: lane select, sign/zero extension on loads, read-modify-write for sub-word stores.
- Checks alignment and range, and reports faults without touching memory.
- Sits between the datapath's memory stage and the data memory.

---
 rtl/load_store_unit_if.sv | 45 ++++
 rtl/load_store_unit.sv | 210 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit.
// lsu_req_if carries the datapath request/response handshake and is driven by
// the datapath (master) toward the unit (slave).
// lsu_mem_if carries the word-addressed data memory port and is driven by the
// unit (master) toward the memory (slave).

interface lsu_req_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddress;
    logic [31:0] reqWriteData;
    logic        respValid;
    logic        respError;
    logic [31:0] loadData;

    modport master (
        output reqValid, reqWrite, reqFunct3, reqAddress, reqWriteData,
        input  reqReady, respValid, respError, loadData
    );

    modport slave (
        input  reqValid, reqWrite, reqFunct3, reqAddress, reqWriteData,
        output reqReady, respValid, respError, loadData
    );
endinterface

interface lsu_mem_if;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] memReadData;

    modport master (
        output memAddress, memWriteData, memWrite, memRead,
        input  memReadData
    );

    modport slave (
        input  memAddress, memWriteData, memWrite, memRead,
        output memReadData
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts byte/halfword/word loads and stores from the
// datapath, checks alignment, range and funct3 legality, and drives a
// word-addressed data memory. Sub-word stores use read-modify-write.
// Memory strobes are decoded from the state register so an asynchronous
// reset removes them instantly and no partial write can occur.

module load_store_unit #(
    parameter int MEM_WORDS = 32
) (
    input  logic      clock,
    input  logic      reset,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        write_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        error_r;
    logic [31:0] load_data_r;
    logic        accept_s;
    logic        error_s;
    logic [31:0] word_addr_s;

    // Flags a request that must not touch memory: illegal funct3,
    // misalignment for its size, or a word index beyond the memory.
    function automatic logic request_error(input logic wr, input logic [2:0] f3,
                                           input logic [31:0] a);
        logic ill;
        logic mis;
        logic rng;
        case (f3)
            3'b000, 3'b001, 3'b010: ill = 1'b0;
            3'b100, 3'b101:         ill = wr;
            default:                ill = 1'b1;
        endcase
        case (f3)
            3'b001, 3'b101: mis = a[0];
            3'b010:         mis = (a[1:0] != 2'b00);
            default:        mis = 1'b0;
        endcase
        rng = (a[31:2] >= 30'(MEM_WORDS));
        return ill | mis | rng;
    endfunction

    // Selects the addressed byte/halfword lane and sign- or zero-extends it.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Replaces the addressed byte or halfword of the old word with store data.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] data,
                                                input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [31:0] r;
        r = old_word;
        case (f3[1:0])
            2'b00: r[{lane, 3'b000} +: 8] = data[7:0];
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = data[15:0];
                end else begin
                    r[15:0] = data[15:0];
                end
            end
            default: r = data;
        endcase
        return r;
    endfunction

    assign accept_s    = (state_r == IDLE) && req.reqValid;
    assign error_s     = request_error(req.reqWrite, req.reqFunct3, req.reqAddress);
    assign word_addr_s = {addr_r[31:2], 2'b00};

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latch the request and its error verdict on the accept edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_r  <= 1'b0;
            funct3_r <= 3'd0;
            addr_r   <= 32'd0;
            wdata_r  <= 32'd0;
            error_r  <= 1'b0;
        end else if (accept_s) begin
            write_r  <= req.reqWrite;
            funct3_r <= req.reqFunct3;
            addr_r   <= req.reqAddress;
            wdata_r  <= req.reqWriteData;
            error_r  <= error_s;
        end
    end

    // Capture the extended load result when the memory word arrives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_data_r <= 32'd0;
        end else if ((state_r == WAIT) && !write_r) begin
            load_data_r <= extend_load(mem.memReadData, funct3_r, addr_r[1:0]);
        end
    end

    // Next-state sequencing through read, read-modify-write or direct write.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req.reqValid) begin
                    if (error_s) begin
                        state_next_s = RESP;
                    end else if (req.reqWrite && (req.reqFunct3 == 3'b010)) begin
                        state_next_s = WRITE;
                    end else begin
                        state_next_s = READ;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ:    state_next_s = WAIT;
            WAIT:    state_next_s = RESP;
            WRITE:   state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        req.reqReady     = 1'b0;
        req.respValid    = 1'b0;
        req.respError    = 1'b0;
        req.loadData     = load_data_r;
        mem.memAddress   = 32'd0;
        mem.memWriteData = 32'd0;
        mem.memWrite     = 1'b0;
        mem.memRead      = 1'b0;
        case (state_r)
            IDLE: req.reqReady = 1'b1;
            READ: begin
                mem.memRead    = 1'b1;
                mem.memAddress = word_addr_s;
            end
            WAIT: begin
                mem.memAddress = word_addr_s;
                if (write_r) begin
                    mem.memWrite     = 1'b1;
                    mem.memWriteData = merge_store(mem.memReadData, wdata_r,
                                                   funct3_r, addr_r[1:0]);
                end else begin
                    mem.memWrite     = 1'b0;
                end
            end
            WRITE: begin
                mem.memWrite     = 1'b1;
                mem.memAddress   = word_addr_s;
                mem.memWriteData = wdata_r;
            end
            RESP: begin
                req.respValid = 1'b1;
                req.respError = error_r;
                if (write_r || error_r) begin
                    req.loadData = 32'd0;
                end else begin
                    req.loadData = load_data_r;
                end
            end
            default: req.reqReady = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests, a simple word memory, and a
// reference model that predicts every output cycle by cycle from the access
// rules (latency per access kind, lane/extension arithmetic, error rules).

module tb_load_store_unit;

    localparam int NC = 512;

    logic clock;
    logic reset;

    lsu_req_if rq ();
    lsu_mem_if mb ();

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clock (clock),
        .reset (reset),
        .req   (rq),
        .mem   (mb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;
    int resp_count = 0;
    int acc_count = 0;
    int n_issued = 0;
    logic [31:0] last_wr_data = 32'd0;

    // Simple memory: write on the edge, read data valid the next cycle.
    logic [31:0] mem [32] = '{default: 32'd0};
    always @(posedge clock) begin
        if (mb.memWrite && mb.memAddress[31:2] < 30'd32) mem[mb.memAddress[6:2]] <= mb.memWriteData;
        if (mb.memRead && mb.memAddress[31:2] < 30'd32) mb.memReadData <= mem[mb.memAddress[6:2]];
    end
    initial mb.memReadData = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          e_ready [NC];
    bit          e_resp  [NC];
    bit          e_err   [NC];
    bit          e_rd    [NC];
    bit          e_wr    [NC];
    bit          e_wdchk [NC];
    logic [31:0] e_load  [NC];
    logic [31:0] e_addr  [NC];
    logic [31:0] e_wdata [NC];
    logic [31:0] ref_mem [32] = '{default: 32'd0};
    int cyc = 0;
    int busy_end = -1;

    task automatic clear_slot(input int c);
        e_ready[c] = 1'b1; e_resp[c] = 1'b0; e_err[c] = 1'b0; e_rd[c] = 1'b0;
        e_wr[c] = 1'b0; e_wdchk[c] = 1'b1; e_load[c] = 32'd0; e_addr[c] = 32'd0;
        e_wdata[c] = 32'd0;
    endtask

    task automatic schedule(input int k, input logic w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d);
        bit ill, mis, rng, err;
        int lane, lat, half;
        logic [31:0] word, v, wa;
        ill  = (f3 == 3'd3) || (f3 >= 3'd6) || (w && f3 >= 3'd4);
        mis  = ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) || (f3 == 3'd2 && (a % 4 != 0));
        rng  = (a / 4) >= 32;
        err  = ill || mis || rng;
        lane = int'(a % 4);
        half = lane / 2;
        wa   = a - (a % 4);
        word = rng ? 32'd0 : ref_mem[a[6:2]];
        lat  = err ? 1 : ((w && f3 == 3'd2) ? 2 : 3);
        for (int c = k + 1; c <= k + lat; c++) e_ready[c] = 1'b0;
        busy_end = k + lat;
        acc_count++;
        if (err) begin
            e_resp[k+1] = 1'b1; e_err[k+1] = 1'b1; e_load[k+1] = 32'd0;
        end else if (w && f3 == 3'd2) begin
            e_wr[k+1] = 1'b1; e_addr[k+1] = wa; e_wdata[k+1] = d;
            e_resp[k+2] = 1'b1;
        end else if (!w) begin
            if (f3 == 3'd0 || f3 == 3'd4) begin
                v = (word >> (8 * lane)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end else if (f3 == 3'd1 || f3 == 3'd5) begin
                v = (word >> (16 * half)) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end else begin
                v = word;
            end
            e_rd[k+1] = 1'b1; e_addr[k+1] = wa; e_wdchk[k+1] = 1'b0;
            e_addr[k+2] = wa; e_wdchk[k+2] = 1'b0;
            e_resp[k+3] = 1'b1; e_load[k+3] = v;
        end else begin
            if (f3 == 3'd0)
                v = (word & ~(32'hFF << (8 * lane))) | ((d & 32'hFF) << (8 * lane));
            else
                v = (word & ~(32'hFFFF << (16 * half))) | ((d & 32'hFFFF) << (16 * half));
            e_rd[k+1] = 1'b1; e_addr[k+1] = wa; e_wdchk[k+1] = 1'b0;
            e_wr[k+2] = 1'b1; e_addr[k+2] = wa; e_wdata[k+2] = v;
            e_resp[k+3] = 1'b1;
        end
    endtask

    initial begin
        for (int c = 0; c < NC; c++) clear_slot(c);
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                for (int c = cyc; c < cyc + 6 && c < NC; c++) clear_slot(c);
                busy_end = cyc - 1;
            end else if (cyc < NC - 8) begin
                if (e_wr[cyc]) ref_mem[e_addr[cyc][6:2]] = e_wdata[cyc];
                if (rq.reqValid && cyc > busy_end)
                    schedule(cyc, rq.reqWrite, rq.reqFunct3, rq.reqAddress, rq.reqWriteData);
                cyc = cyc + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (reset === 1'b1 && cyc < NC) begin
            chk("reqReady", rq.reqReady, e_ready[cyc]);
            chk("respValid", rq.respValid, e_resp[cyc]);
            chk("memRead", mb.memRead, e_rd[cyc]);
            chk("memWrite", mb.memWrite, e_wr[cyc]);
            chk("memAddress", mb.memAddress, e_addr[cyc]);
            if (e_wdchk[cyc]) chk("memWriteData", mb.memWriteData, e_wdata[cyc]);
            if (e_resp[cyc]) begin
                chk("respError", rq.respError, e_err[cyc]);
                chk("loadData", rq.loadData, e_load[cyc]);
            end
            if (rq.respValid === 1'b1) resp_count++;
            if (mb.memWrite === 1'b1) last_wr_data = mb.memWriteData;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic keep_valid);
        bit got;
        got = 0;
        rq.reqValid = 1'b1; rq.reqWrite = w; rq.reqFunct3 = f3;
        rq.reqAddress = a; rq.reqWriteData = d;
        for (int i = 0; i < 20; i++) begin
            if (rq.reqReady === 1'b1) begin got = 1; break; end
            @(negedge clock);
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout addr=%h", a);
        end
        n_issued++;
        @(posedge clock);
        @(negedge clock);
        if (!keep_valid) rq.reqValid = 1'b0;
    endtask

    task automatic wait_resp(output logic err, output logic [31:0] data);
        bit got;
        got = 0; err = 1'bx; data = 32'hx;
        for (int i = 0; i < 12; i++) begin
            if (rq.respValid === 1'b1) begin
                got = 1; err = rq.respError; data = rq.loadData; break;
            end
            @(negedge clock);
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL resp_timeout actual=none expected=respValid");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic        err;
        logic [31:0] data;
        reset = 1'b0;
        rq.reqValid = 1'b0; rq.reqWrite = 1'b0; rq.reqFunct3 = 3'd0;
        rq.reqAddress = 32'd0; rq.reqWriteData = 32'd0;
        repeat (3) @(negedge clock);
        chk("rst_memWrite", mb.memWrite, 32'd0);
        #2 reset = 1'b1;
        @(negedge clock);
        chk("rst_reqReady", rq.reqReady, 32'd1);
        chk("rst_loadData", rq.loadData, 32'd0);
        chk("rst_memAddress", mb.memAddress, 32'd0);

        // sw then sub-word loads of word 2
        issue(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF, 1'b0);
        wait_resp(err, data);
        chk("sw_err", err, 32'd0);
        chk("sw_wrdata", last_wr_data, 32'hDEAD_BEEF);
        issue(1'b0, 3'b000, 32'h0B, 32'd0, 1'b0); wait_resp(err, data);
        chk("lb_0B", data, 32'hFFFF_FFDE);
        issue(1'b0, 3'b100, 32'h0B, 32'd0, 1'b0); wait_resp(err, data);
        chk("lbu_0B", data, 32'h0000_00DE);
        issue(1'b0, 3'b001, 32'h0A, 32'd0, 1'b0); wait_resp(err, data);
        chk("lh_0A", data, 32'hFFFF_DEAD);
        issue(1'b0, 3'b101, 32'h08, 32'd0, 1'b0); wait_resp(err, data);
        chk("lhu_08", data, 32'h0000_BEEF);

        // read-modify-write stores
        issue(1'b1, 3'b000, 32'h09, 32'h0000_0055, 1'b0); wait_resp(err, data);
        chk("sb_merge", last_wr_data, 32'hDEAD_55EF);
        issue(1'b1, 3'b001, 32'h0A, 32'h0000_1234, 1'b0); wait_resp(err, data);
        chk("sh_merge", last_wr_data, 32'h1234_55EF);

        // faults
        issue(1'b0, 3'b010, 32'h06, 32'd0, 1'b0); wait_resp(err, data);
        chk("lw_misaligned", err, 32'd1);
        issue(1'b0, 3'b001, 32'h03, 32'd0, 1'b0); wait_resp(err, data);
        chk("lh_misaligned", err, 32'd1);
        issue(1'b0, 3'b010, 32'h80, 32'd0, 1'b0); wait_resp(err, data);
        chk("lw_range", err, 32'd1);
        chk("lw_range_data", data, 32'd0);

        // reset during the write cycle of an sb
        issue(1'b1, 3'b000, 32'h08, 32'h0000_00AA, 1'b0);
        @(negedge clock);
        chk("abort_pre_memWrite", mb.memWrite, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_memWrite", mb.memWrite, 32'd0);
        chk("abort_memRead", mb.memRead, 32'd0);
        chk("abort_idle", rq.reqReady, 32'd1);
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        issue(1'b0, 3'b010, 32'h08, 32'd0, 1'b0); wait_resp(err, data);
        chk("abort_word_kept", data, 32'h1234_55EF);

        // back-to-back with reqValid held high
        issue(1'b1, 3'b010, 32'h10, 32'hA5A5_0001, 1'b1);
        issue(1'b0, 3'b010, 32'h10, 32'd0, 1'b1);
        issue(1'b1, 3'b010, 32'h14, 32'h0BAD_F00D, 1'b1);
        issue(1'b0, 3'b010, 32'h14, 32'd0, 1'b0);
        wait_resp(err, data);
        chk("stream_lw", data, 32'h0BAD_F00D);
        repeat (3) @(negedge clock);
        chk("accept_count", acc_count, n_issued);
        chk("resp_count", resp_count, n_issued - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
